mem_line_controller: RTL
========================

Name: mem_line_controller

Overview:
- Line-granular front end for the single-port word-wide main memory.
- Arbitrates between a cache-fill requester (line read) and a writeback requester (line write).
- Sequences each granted request into LINE_WORDS consecutive word accesses on the memory port, streaming fill data back beat by beat.
- Sits between the BDI cache's miss/eviction logic and main memory.

Parameters:
- WORD_WIDTH, 32: data word width; must match the memory.
- ADDR_WIDTH, 32: byte address width. The memory word address is ADDR_WIDTH-2 bits.
- LINE_WORDS, 8: words per line. Power of two, >= 2.
  - OFF = $clog2(LINE_WORDS).
  - LA = ADDR_WIDTH-2-OFF (line address width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- fill_req  in  1  line read requested; held until fill_gnt
- fill_addr  in  LA  line address of fill
- fill_gnt  out  1  one-cycle pulse: fill accepted, fill_addr captured
- fill_data  out  WORD_WIDTH  fill beat data
- fill_valid  out  1  fill beat valid; no backpressure, sink must accept
- fill_last  out  1  with fill_valid on beat LINE_WORDS-1
- wb_req  in  1  line write requested; held until wb_gnt
- wb_addr  in  LA  line address of writeback
- wb_gnt  out  1  one-cycle pulse: writeback accepted, wb_addr captured
- wb_data  in  WORD_WIDTH  writeback beat data
- wb_data_valid  in  1  writeback beat offered
- wb_data_ready  out  1  writeback beat taken when valid&ready
- wb_done  out  1  pulse in the cycle the last writeback beat is taken
- mem_write_data  out  WORD_WIDTH  to memory write_data
- mem_write_addr  out  ADDR_WIDTH-2  to memory write_addr
- mem_write_en  out  1  to memory write_en
- mem_read_addr  out  ADDR_WIDTH-2  to memory read_addr
- mem_read_addr_valid  out  1  to memory read_addr_valid
- mem_read_data  in  WORD_WIDTH  from memory read_data
- mem_read_ready  in  1  from memory read_ready
- mem_read_valid  in  1  from memory read_valid

Behaviour:
- Reset:
  - When rst==0 at a rising edge: state=IDLE, beat counter cnt=0, base address=0, rr_last_wb=1.
  - Reset mid-operation aborts the transfer: no further memory writes or reads are issued.
  - Memory words already written stay written.
- Outputs are 0 whenever state==IDLE and no grant fires, including during and after reset:
  - fill_gnt, wb_gnt, fill_valid, fill_last, wb_data_ready, wb_done, mem_write_en, mem_read_addr_valid.
- State IDLE:
  - If exactly one request is pending, grant it.
  - If both are pending, grant fill when rr_last_wb==1, else grant writeback.
  - The grant pulse is combinational in IDLE. At the edge: capture the address, cnt=0, update rr_last_wb (1 for writeback, 0 for fill).
  - Next state: fill -> RD_REQ; writeback -> WB.
- State WB:
  - wb_data_ready=1.
  - mem_write_en = wb_data_valid.
  - mem_write_addr = {base, cnt}; mem_write_data = wb_data.
  - On each accepted beat: cnt++.
  - On the beat with cnt==LINE_WORDS-1: wb_done=1 and return to IDLE.
  - Stalls indefinitely while wb_data_valid==0.
- State RD_REQ:
  - mem_read_addr_valid=1, mem_read_addr={base, cnt}.
  - When mem_read_ready==1: -> RD_WAIT. Otherwise hold.
  - After a writeback the memory drops read_ready for one cycle; this is expected.
- State RD_WAIT:
  - mem_read_addr_valid=0.
  - When mem_read_valid==1:
    - fill_valid=1, fill_data=mem_read_data.
    - fill_last=(cnt==LINE_WORDS-1).
    - cnt++.
    - Next state: IDLE if last, else RD_REQ.
- Throughput:
  - Fill: 2 cycles per word with memory ready. The first beat appears 2 cycles after the grant cycle. A full line takes 2*LINE_WORDS cycles after the grant cycle.
  - Writeback: 1 word per cycle with continuous wb_data_valid.
- Exclusivity:
  - mem_write_en and mem_read_addr_valid are never 1 in the same cycle.
  - Only one line transfer is in flight.
  - Requests arriving mid-transfer wait in IDLE arbitration.
- Address arithmetic:
  - cnt is OFF bits wide and wraps to 0 after the last beat.
  - The base is not incremented, so a line never crosses into the neighbouring line.
- Unused data outputs (mem_write_data, mem_read_addr, fill_data) are don't-care when their strobes are low; the implementation drives them from the muxes above, not X.

Optional Feature:
- Macro: MEM_CTRL_WB_PRIORITY_EN.
- Defined: on simultaneous requests in IDLE, writeback always wins. rr_last_wb is not used.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Fill only:
  - Preload memory words 0x40..0x47 with 0xA0..0xA7; fill_req, fill_addr=8.
  - Expect fill_gnt pulse, then 8 fill_valid beats 0xA0..0xA7, 2 cycles apart.
  - fill_last only on 0xA7.
- Writeback then readback:
  - wb_addr=3, 8 beats 0x100..0x107 with continuous valid.
  - Expect mem writes to word addrs 0x18..0x1F on 8 consecutive cycles, wb_done on the 8th.
  - A subsequent fill of line 3 returns 0x100..0x107.
- Simultaneous requests:
  - fill_req and wb_req rise together 3 times after reset.
  - Expect grant order fill, wb, fill.
  - With MEM_CTRL_WB_PRIORITY_EN defined: wb, wb, wb.
- Writeback stall:
  - wb_data_valid low for 5 cycles after beat 2.
  - Expect no mem_write_en during the gap, cnt held, addresses still contiguous, wb_done after beat 7.
- Reset mid-fill:
  - Assert rst=0 on the cycle fill beat 3 is due.
  - Expect all outputs 0 the next cycle and state IDLE.
  - A new wb_req is granted within 1 cycle of rst=1.
- Exclusivity check:
  - Random mixed traffic of 200 lines against a scoreboard.
  - Assert mem_write_en & mem_read_addr_valid never both high.
  - Every fill returns the last written data.

Source files
------------

// File: rtl/mem_line_controller.sv
// Line-granular memory front end: arbitrates fill (line read) vs writeback (line write)
// and sequences LINE_WORDS word accesses. Define MEM_CTRL_WB_PRIORITY_EN for fixed writeback priority.
//
// state     | meaning
// S_IDLE    | arbitrating; grant is combinational on the pending requests
// S_WB      | accepting writeback beats, one memory write per accepted beat
// S_RD_REQ  | presenting the read address until memory signals ready
// S_RD_WAIT | waiting for read data; each returned word is a fill beat
module mem_line_controller #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 8,
  localparam int OFF = $clog2(LINE_WORDS),
  localparam int LA  = ADDR_WIDTH - 2 - OFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req,
  input  logic [LA-1:0]         fill_addr,
  output logic                  fill_gnt,
  output logic [WORD_WIDTH-1:0] fill_data,
  output logic                  fill_valid,
  output logic                  fill_last,
  input  logic                  wb_req,
  input  logic [LA-1:0]         wb_addr,
  output logic                  wb_gnt,
  input  logic [WORD_WIDTH-1:0] wb_data,
  input  logic                  wb_data_valid,
  output logic                  wb_data_ready,
  output logic                  wb_done,
  output logic [WORD_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-3:0] mem_write_addr,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-3:0] mem_read_addr,
  output logic                  mem_read_addr_valid,
  input  logic [WORD_WIDTH-1:0] mem_read_data,
  input  logic                  mem_read_ready,
  input  logic                  mem_read_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_RD_REQ, S_RD_WAIT} state_t;

  state_t          r_state;
  logic [OFF-1:0]  r_cnt;
  logic [LA-1:0]   r_base;
  logic            r_rr_last_wb;

  logic            w_pick_fill;
  logic            w_idle_ok;
  logic            w_last;
  logic [ADDR_WIDTH-3:0] w_beat_addr;

`ifdef MEM_CTRL_WB_PRIORITY_EN
  assign w_pick_fill = fill_req & ~wb_req;
`else
  assign w_pick_fill = fill_req & (~wb_req | r_rr_last_wb);
`endif

  // Grants are suppressed while reset is held so nothing is accepted mid-reset.
  assign w_idle_ok   = (r_state == S_IDLE) & rst;
  assign fill_gnt    = w_idle_ok & w_pick_fill;
  assign wb_gnt      = w_idle_ok & wb_req & ~w_pick_fill;
  assign w_last      = (r_cnt == OFF'(LINE_WORDS - 1));
  assign w_beat_addr = {r_base, r_cnt};

  always_comb begin
    wb_data_ready       = 1'b0;
    mem_write_en        = 1'b0;
    wb_done             = 1'b0;
    mem_read_addr_valid = 1'b0;
    fill_valid          = 1'b0;
    fill_last           = 1'b0;
    mem_write_addr      = w_beat_addr;
    mem_read_addr       = w_beat_addr;
    mem_write_data      = wb_data;
    fill_data           = mem_read_data;
    if (rst) begin
      case (r_state)
        S_WB: begin
          wb_data_ready = 1'b1;
          mem_write_en  = wb_data_valid;
          wb_done       = wb_data_valid & w_last;
        end
        S_RD_REQ:  mem_read_addr_valid = 1'b1;
        S_RD_WAIT: begin
          fill_valid = mem_read_valid;
          fill_last  = mem_read_valid & w_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_base       <= '0;
      r_rr_last_wb <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fill_gnt) begin
            r_base       <= fill_addr;
            r_cnt        <= '0;
            r_rr_last_wb <= 1'b0;
            r_state      <= S_RD_REQ;
          end else if (wb_gnt) begin
            r_base       <= wb_addr;
            r_cnt        <= '0;
            r_rr_last_wb <= 1'b1;
            r_state      <= S_WB;
          end
        end
        S_WB: begin
          if (wb_data_valid) begin
            r_cnt <= r_cnt + OFF'(1);
            if (w_last) r_state <= S_IDLE;
          end
        end
        S_RD_REQ: begin
          if (mem_read_ready) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_read_valid) begin
            r_cnt   <= r_cnt + OFF'(1);
            r_state <= w_last ? S_IDLE : S_RD_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
